// File: rtl/armleocpu_storebuf_if.sv
// Store buffer handshake bundle: execute-stage request channel, registered
// error report and the data-bus write channel.
// master = store requester / bus environment, slave = armleocpu_storebuf.
interface armleocpu_storebuf_if;
  // Request channel from execute stage
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_addr;
  logic [2:0]  s_type;
  logic [31:0] s_data;
  // Registered reject report
  logic        s_err_valid;
  logic        s_err_missaligned;
  logic        s_err_unknowntype;
  // Data-bus write channel
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  modport master (
    output s_valid, s_addr, s_type, s_data, m_ready,
    input  s_ready, s_err_valid, s_err_missaligned, s_err_unknowntype,
           m_valid, m_addr, m_wdata, m_wstrb
  );

  modport slave (
    input  s_valid, s_addr, s_type, s_data, m_ready,
    output s_ready, s_err_valid, s_err_missaligned, s_err_unknowntype,
           m_valid, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/armleocpu_storebuf.sv
// armleocpu_storebuf: store realigner + in-order store FIFO.
// Takes right-aligned store data, shifts it into the addressed byte lanes,
// builds the byte strobe, rejects misaligned / unknown-type stores with a
// registered one-cycle error pulse and drains legal stores to the data bus.
// Optional feature: define ARMLEOCPU_STOREBUF_BYPASS_EN to let a legal store
// presented while the FIFO is empty reach the bus in the same cycle.
module armleocpu_storebuf #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  armleocpu_storebuf_if.slave   bus,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty
);

  // funct3 store encodings
  localparam logic [2:0] STORE_BYTE = 3'b000;
  localparam logic [2:0] STORE_HALF = 3'b001;
  localparam logic [2:0] STORE_WORD = 3'b010;

  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;

  // Entry storage: word address, lane-aligned data, strobe
  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  strb_mem [DEPTH];

  logic        full;
  logic [1:0]  off;
  logic [3:0]  req_strb;
  logic [31:0] lane_mask;
  logic [31:0] req_wdata;
  logic        req_mis;
  logic        req_unk;
  logic        req_legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        bypass_take;

  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];

  // Decode store type, check alignment and build strobe
  always_comb begin
    off      = bus.s_addr[1:0];
    req_strb = '0;
    req_mis  = 1'b0;
    req_unk  = 1'b0;
    case (bus.s_type)
      STORE_BYTE: req_strb = 4'b0001 << off;
      STORE_HALF: begin
        req_strb = 4'b0011 << off;
        req_mis  = off[0];
      end
      STORE_WORD: begin
        req_strb = 4'b1111;
        req_mis  = (off != 2'b00);
      end
      default: req_unk = 1'b1;
    endcase
  end

  // Shift data into its lanes; lanes outside the strobe are forced to zero
  always_comb begin
    lane_mask = {{8{req_strb[3]}}, {8{req_strb[2]}}, {8{req_strb[1]}}, {8{req_strb[0]}}};
    req_wdata = (bus.s_data << {off, 3'b000}) & lane_mask;
  end

  // FIFO status derived from the pointer pair
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
            (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    count = wr_ptr - rd_ptr;
  end

  // Request acceptance: ready only depends on occupancy, never on s_valid
  always_comb begin
    bus.s_ready = !full;
    req_legal   = !req_mis && !req_unk;
    accept      = bus.s_valid && !full;
  end

`ifdef ARMLEOCPU_STOREBUF_BYPASS_EN
  // Bus side: empty FIFO forwards a legal request straight through
  always_comb begin
    bypass_take = empty && bus.s_valid && req_legal;
    pop         = !empty && bus.m_ready;
    // A forwarded store that the bus takes this cycle never occupies an entry
    push        = accept && req_legal && !(bypass_take && bus.m_ready);
    if (bypass_take) begin
      bus.m_valid = 1'b1;
      bus.m_addr  = {bus.s_addr[31:2], 2'b00};
      bus.m_wdata = req_wdata;
      bus.m_wstrb = req_strb;
    end else begin
      bus.m_valid = !empty;
      bus.m_addr  = empty ? '0 : {addr_mem[rd_idx], 2'b00};
      bus.m_wdata = empty ? '0 : data_mem[rd_idx];
      bus.m_wstrb = empty ? '0 : strb_mem[rd_idx];
    end
  end
`else
  // Bus side: head of FIFO only; outputs read zero while empty
  always_comb begin
    bypass_take = 1'b0;
    pop         = !empty && bus.m_ready;
    push        = accept && req_legal;
    bus.m_valid = !empty;
    bus.m_addr  = empty ? '0 : {addr_mem[rd_idx], 2'b00};
    bus.m_wdata = empty ? '0 : data_mem[rd_idx];
    bus.m_wstrb = empty ? '0 : strb_mem[rd_idx];
  end
`endif

  // Pointer update; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry write at the tail; storage needs no reset since reads are gated by empty
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_idx] <= bus.s_addr[31:2];
      data_mem[wr_idx] <= req_wdata;
      strb_mem[wr_idx] <= req_strb;
    end
  end

  // One-cycle error pulse for an accepted illegal request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.s_err_valid       <= 1'b0;
      bus.s_err_missaligned <= 1'b0;
      bus.s_err_unknowntype <= 1'b0;
    end else begin
      bus.s_err_valid       <= accept && !req_legal;
      bus.s_err_missaligned <= accept && req_mis;
      bus.s_err_unknowntype <= accept && req_unk;
    end
  end

endmodule

// File: tb/tb_armleocpu_storebuf.sv
// Randomized self-checking bench for armleocpu_storebuf against a queue-based
// reference model of the store buffer behaviour.
module tb_armleocpu_storebuf;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned DEPTH_LOG2 = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  logic                clk;
  logic                rst_n;
  logic [DEPTH_LOG2:0] count;
  logic                empty;

  armleocpu_storebuf_if bus ();

  armleocpu_storebuf #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .count (count),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t q[$];
  bit   e_err_v, e_err_mis, e_err_unk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit known_type(input logic [2:0] t);
    return (t == 3'd0) || (t == 3'd1) || (t == 3'd2);
  endfunction

  function automatic int unsigned size_of(input logic [2:0] t);
    return 1 << t;  // 1, 2 or 4 bytes for known types
  endfunction

  function automatic bit is_legal(input logic [2:0] t, input logic [31:0] a);
    if (!known_type(t)) return 1'b0;
    return (a % size_of(t)) == 0;
  endfunction

  function automatic ent_t make_entry(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int unsigned o;
    o = a % 4;
    e.addr = a - o;
    e.data = '0;
    e.strb = '0;
    for (int unsigned k = 0; k < size_of(t); k++) begin
      if (o + k < 4) begin
        e.data[(o + k) * 8 +: 8] = d[k * 8 +: 8];
        e.strb[o + k] = 1'b1;
      end
    end
    return e;
  endfunction

  // One clock of stimulus; model advanced at the edge, outputs checked 1ns after
  task automatic cycle(input bit v, input logic [31:0] a, input logic [2:0] t,
                       input logic [31:0] d, input bit mr);
    bit exp_ready, acc, legal, bypassed, exp_mv;
    bus.s_valid = v;
    bus.s_addr  = a;
    bus.s_type  = t;
    bus.s_data  = d;
    bus.m_ready = mr;
    #1;
    exp_ready = q.size() < DEPTH;
    check("s_ready", {31'b0, bus.s_ready}, {31'b0, exp_ready});
    legal = is_legal(t, a);
`ifdef ARMLEOCPU_STOREBUF_BYPASS_EN
    check("m_valid_comb", {31'b0, bus.m_valid}, {31'b0, (q.size() > 0) || (v && legal)});
`endif
    @(posedge clk);
    acc      = v && exp_ready;
    bypassed = 1'b0;
`ifdef ARMLEOCPU_STOREBUF_BYPASS_EN
    if (q.size() == 0 && acc && legal && mr) bypassed = 1'b1;
`endif
    if (q.size() > 0 && mr) void'(q.pop_front());
    if (acc && legal && !bypassed) q.push_back(make_entry(t, a, d));
    e_err_v   = acc && !legal;
    e_err_mis = acc && known_type(t) && !legal;
    e_err_unk = acc && !known_type(t);
    #1;
    exp_mv = q.size() > 0;
`ifdef ARMLEOCPU_STOREBUF_BYPASS_EN
    exp_mv = exp_mv || (v && legal);
`endif
    check("m_valid", {31'b0, bus.m_valid}, {31'b0, exp_mv});
    if (q.size() > 0) begin
      check("m_addr",  bus.m_addr,  q[0].addr);
      check("m_wdata", bus.m_wdata, q[0].data);
      check("m_wstrb", {28'b0, bus.m_wstrb}, {28'b0, q[0].strb});
    end
    check("count", {29'b0, count}, q.size());
    check("empty", {31'b0, empty}, {31'b0, q.size() == 0});
    check("err_valid", {31'b0, bus.s_err_valid},       {31'b0, e_err_v});
    check("err_mis",   {31'b0, bus.s_err_missaligned}, {31'b0, e_err_mis});
    check("err_unk",   {31'b0, bus.s_err_unknowntype}, {31'b0, e_err_unk});
  endtask

  task automatic idle(input bit mr);
    cycle(1'b0, 32'h0, 3'd0, 32'h0, mr);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_m_valid"}, {31'b0, bus.m_valid}, 32'd0);
    check({tag, "_count"},   {29'b0, count},       32'd0);
    check({tag, "_empty"},   {31'b0, empty},       32'd1);
    check({tag, "_err"},     {31'b0, bus.s_err_valid}, 32'd0);
    check({tag, "_m_addr"},  bus.m_addr,  32'd0);
    check({tag, "_m_wdata"}, bus.m_wdata, 32'd0);
    check({tag, "_m_wstrb"}, {28'b0, bus.m_wstrb}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_addr  = '0;
    bus.s_type  = '0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    e_err_v = 0; e_err_mis = 0; e_err_unk = 0;
    #12;
    reset_checks("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte store into top lane
    cycle(1'b1, 32'h0000_1003, 3'd0, 32'h0000_00AB, 1'b0);
    check("t1_addr",  bus.m_addr,  32'h0000_1000);
    check("t1_wdata", bus.m_wdata, 32'hAB00_0000);
    check("t1_wstrb", {28'b0, bus.m_wstrb}, 32'h8);
    idle(1'b1);

    // Half store aligned, then misaligned
    cycle(1'b1, 32'h0000_2002, 3'd1, 32'h1234_CDEF, 1'b0);
    check("t2_wdata", bus.m_wdata, 32'hCDEF_0000);
    check("t2_wstrb", {28'b0, bus.m_wstrb}, 32'hC);
    cycle(1'b1, 32'h0000_2001, 3'd1, 32'h1234_CDEF, 1'b0);
    check("t2_err",   {31'b0, bus.s_err_missaligned}, 32'd1);
    check("t2_count", {29'b0, count}, 32'd1);
    idle(1'b1);
    idle(1'b1);

    // Unknown type and misaligned word
    cycle(1'b1, 32'h0000_3000, 3'b011, 32'h5555_5555, 1'b1);
    check("t3_unk", {31'b0, bus.s_err_unknowntype}, 32'd1);
    check("t3_mis", {31'b0, bus.s_err_missaligned}, 32'd0);
    cycle(1'b1, 32'h0000_3002, 3'd2, 32'h5555_5555, 1'b1);
    check("t3_wmis", {31'b0, bus.s_err_missaligned}, 32'd1);
    idle(1'b1);

    // Fill to full with bus stalled, then drain in order
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h0000_4000 + 32'(i * 4), 3'd2, 32'hA0 + 32'(i), 1'b0);
    check("t4_count", {29'b0, count}, 32'd4);
    check("t4_ready", {31'b0, bus.s_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t4_order", bus.m_wdata, 32'hA0 + 32'(i));
      idle(1'b1);
    end
    check("t4_empty", {31'b0, empty}, 32'd1);

    // Push and pop in the same cycle with two queued
    cycle(1'b1, 32'h0000_5000, 3'd2, 32'h1111_1111, 1'b0);
    cycle(1'b1, 32'h0000_5004, 3'd2, 32'h2222_2222, 1'b0);
    cycle(1'b1, 32'h0000_5008, 3'd2, 32'h3333_3333, 1'b1);
    check("t5_count", {29'b0, count}, 32'd2);
    check("t5_head",  bus.m_wdata, 32'h2222_2222);

    // Asynchronous reset with three queued and an error pulse pending
    cycle(1'b1, 32'h0000_600C, 3'd2, 32'h4444_4444, 1'b0);
    cycle(1'b1, 32'h0000_6001, 3'd2, 32'h4444_4444, 1'b0);
    check("t6_pre_err", {31'b0, bus.s_err_valid}, 32'd1);
    check("t6_pre_cnt", {29'b0, count}, 32'd3);
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks("t6");
    q.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [2:0]  t;
      int unsigned r;
      r = $urandom_range(0, 9);
      t = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      cycle($urandom_range(0, 3) != 0, a, t, $urandom,
            ((n / 64) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
